// File: rtl/ldl_rr_arbiter.sv
// Round-robin arbiter: a rotating priority pointer feeds a lowest-index-first
// encoder, and the registered one-hot grant is held until release or hold-limit revoke.

module LDL_ring_shift_right #(
    parameter int WIDTH = 8,
    parameter int SW    = 3
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [SW-1:0]    i_sel,
    output logic [WIDTH-1:0] o_data
);
    logic [2*WIDTH-1:0] w_dbl;

    // Shifting the doubled vector makes bit k of the low half equal data[(sel+k) mod WIDTH].
    assign w_dbl  = {i_data, i_data};
    assign o_data = WIDTH'(w_dbl >> i_sel);
endmodule

module ldl_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 0,
    parameter int HW       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         req,
    output logic [WIDTH-1:0]         gnt,
    output logic                     gnt_vld,
    output logic [$clog2(WIDTH)-1:0] gnt_idx,
    output logic                     revoke
);
    localparam int IW = $clog2(WIDTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // With no hold limit the counter only needs to stop before it wraps.
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

    logic [0:0]       r_state;
    logic [IW-1:0]    r_ptr;
    logic [HW-1:0]    r_hold_cnt;

    logic [WIDTH-1:0] w_rot;
    logic [IW-1:0]    w_k;
    logic [IW-1:0]    w_win;
    logic [WIDTH-1:0] w_win_oh;
    logic             w_any_req;
    logic             w_owner_req;
    logic             w_others_req;
    logic             w_revoke;

    LDL_ring_shift_right #(
        .WIDTH (WIDTH),
        .SW    (IW)
    ) u_rot (
        .i_data (req),
        .i_sel  (r_ptr),
        .o_data (w_rot)
    );

    always_comb begin
        w_k = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_rot[i]) w_k = IW'(i);
        end
    end

    assign w_win        = r_ptr + w_k;
    assign w_win_oh     = {{(WIDTH-1){1'b0}}, 1'b1} << w_win;
    assign w_any_req    = |req;
    assign w_owner_req  = req[gnt_idx];
    assign w_others_req = |(req & ~gnt);
    assign w_revoke     = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_SAT)
                          && w_owner_req && w_others_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            gnt        <= '0;
            gnt_vld    <= 1'b0;
            gnt_idx    <= '0;
            revoke     <= 1'b0;
        end else begin
            revoke <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ST_GRANT;
                        gnt        <= w_win_oh;
                        gnt_vld    <= 1'b1;
                        gnt_idx    <= w_win;
                        r_hold_cnt <= HW'(1);
                    end
                end
                default: begin
                    // Release is checked first so a simultaneous drop never pulses revoke.
                    if (!w_owner_req || w_revoke) begin
                        r_state    <= ST_IDLE;
                        gnt        <= '0;
                        gnt_vld    <= 1'b0;
                        gnt_idx    <= '0;
                        r_hold_cnt <= '0;
                        r_ptr      <= gnt_idx + IW'(1);
                        revoke     <= w_owner_req;
                    end else if (r_hold_cnt != HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Directed bench for ldl_rr_arbiter: one unlimited-hold instance and one with
// a hold limit of 4, sharing clock and reset.

module tb_ldl_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic [7:0] req_a;
    logic [7:0] gnt_a;
    logic       vld_a;
    logic [2:0] idx_a;
    logic       rev_a;
    logic [7:0] req_b;
    logic [7:0] gnt_b;
    logic       vld_b;
    logic [2:0] idx_b;
    logic       rev_b;

    int n_checks;
    int n_fail;

    ldl_rr_arbiter #(.WIDTH(8), .MAX_HOLD(0), .HW(16)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_a),
        .gnt     (gnt_a),
        .gnt_vld (vld_a),
        .gnt_idx (idx_a),
        .revoke  (rev_a)
    );

    ldl_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4), .HW(16)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_b),
        .gnt     (gnt_b),
        .gnt_vld (vld_b),
        .gnt_idx (idx_b),
        .revoke  (rev_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh_to_idx(input logic [7:0] v);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [7:0] exp_gnt, input logic exp_rev);
        check_eq({tag, ".gnt"}, 32'(gnt_a), 32'(exp_gnt));
        check_eq({tag, ".vld"}, 32'(vld_a), 32'(|exp_gnt));
        check_eq({tag, ".idx"}, 32'(idx_a), oh_to_idx(exp_gnt));
        check_eq({tag, ".rev"}, 32'(rev_a), 32'(exp_rev));
    endtask

    task automatic expect_b(input string tag, input logic [7:0] exp_gnt, input logic exp_rev);
        check_eq({tag, ".gnt"}, 32'(gnt_b), 32'(exp_gnt));
        check_eq({tag, ".vld"}, 32'(vld_b), 32'(|exp_gnt));
        check_eq({tag, ".idx"}, 32'(idx_b), oh_to_idx(exp_gnt));
        check_eq({tag, ".rev"}, 32'(rev_b), 32'(exp_rev));
    endtask

    initial begin
        logic [7:0] bit_mask;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req_a    = 8'h00;
        req_b    = 8'h00;

        // 1: reset, then a single request
        tick();
        expect_a("rst1", 8'h00, 1'b0);
        expect_b("rst1b", 8'h00, 1'b0);
        tick();
        expect_a("rst2", 8'h00, 1'b0);
        rst_n = 1'b1;
        req_a = 8'h04;
        tick();
        expect_a("single_gnt", 8'h04, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_a("single_hold", 8'h04, 1'b0);
        end
        req_a = 8'h00;
        tick();
        expect_a("single_rel", 8'h00, 1'b0);
        // ptr is now 3: requesters 0 and 3 compete, 3 must win
        req_a = 8'h09;
        tick();
        expect_a("ptr3_win", 8'h08, 1'b0);
        req_a = 8'h00;
        tick();
        expect_a("ptr3_rel", 8'h00, 1'b0);

        // 2: rotation fairness from ptr 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            bit_mask = 8'h01 << (g % 8);
            expect_a($sformatf("rot_gnt%0d", g), bit_mask, 1'b0);
            req_a = 8'hFF & ~bit_mask;
            tick();
            expect_a($sformatf("rot_gap%0d", g), 8'h00, 1'b0);
            req_a = 8'hFF;
        end
        req_a = 8'h00;
        tick();
        expect_a("rot_end", 8'h00, 1'b0);

        // 3: wrap-around, ptr forced to 7 through a grant to 6
        req_a = 8'h40;
        tick();
        expect_a("wrap_g6", 8'h40, 1'b0);
        req_a = 8'h00;
        tick();
        expect_a("wrap_r6", 8'h00, 1'b0);
        req_a = 8'h81;
        tick();
        expect_a("wrap_g7", 8'h80, 1'b0);
        req_a = 8'h01;
        tick();
        expect_a("wrap_r7", 8'h00, 1'b0);
        tick();
        expect_a("wrap_g0", 8'h01, 1'b0);
        req_a = 8'h00;
        tick();
        expect_a("wrap_r0", 8'h00, 1'b0);

        // 4: hold limit of 4 with a competing requester
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_b = 8'h03;
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_b($sformatf("hold0_c%0d", c), 8'h01, 1'b0);
        end
        tick();
        expect_b("revoke0", 8'h00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_b($sformatf("hold1_c%0d", c), 8'h02, 1'b0);
        end
        tick();
        expect_b("revoke1", 8'h00, 1'b1);
        tick();
        expect_b("back_to0", 8'h01, 1'b0);
        // lone owner keeps the grant well past the limit
        req_b = 8'h01;
        for (int c = 0; c < 10; c++) begin
            tick();
            expect_b($sformatf("lone_c%0d", c), 8'h01, 1'b0);
        end
        req_b = 8'h00;
        tick();
        expect_b("lone_rel", 8'h00, 1'b0);

        // 5: owner releases in the same cycle the limit is reached (ptr was 1)
        req_b = 8'h03;
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_b($sformatf("sim_c%0d", c), 8'h02, 1'b0);
        end
        req_b = 8'h09;
        tick();
        expect_b("sim_rel", 8'h00, 1'b0);
        tick();
        expect_b("sim_ptr2", 8'h08, 1'b0);

        // 6: reset while requester 4 owns the grant
        req_a = 8'h10;
        tick();
        expect_a("mid_gnt", 8'h10, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_a("mid_rst", 8'h00, 1'b0);
        expect_b("mid_rstb", 8'h00, 1'b0);
        rst_n = 1'b1;
        req_a = 8'h30;
        req_b = 8'h00;
        tick();
        expect_a("post_rst", 8'h10, 1'b0);
        req_a = 8'h00;
        tick();
        expect_a("post_rel", 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ldl_rr_arbiter.md
Name: ldl_rr_arbiter

Overview:
Round-robin arbiter that shares one resource among WIDTH requesters. Fairness comes from rotating the request vector by a registered priority pointer, using an internal LDL_ring_shift_right instance, then applying a lowest-index-first priority encoder. It holds the grant until the winner releases it or an optional hold limit expires. It sits in front of any shared datapath, such as a bus port or memory bank, and its registered one-hot grant directly drives the resource mux select.

Parameters:
WIDTH, 8, number of requesters; power of two, >= 2.
MAX_HOLD, 0, maximum consecutive grant cycles before forced revoke when others are waiting; 0 = unlimited.
HW, 16, width of hold counter; MAX_HOLD must be < 2**HW.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  WIDTH  request vector, bit i = requester i; level, held until done
gnt  output  WIDTH  registered one-hot grant, all-zero when idle
gnt_vld  output  1  registered, = |gnt
gnt_idx  output  $clog2(WIDTH)  registered binary index of granted requester; 0 when idle
revoke  output  1  registered one-cycle pulse in the cycle gnt drops due to MAX_HOLD

Behaviour:
- Reset: rst_n sampled low at a rising edge sets the following: state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_vld=0, gnt_idx=0, revoke=0. Reset mid-grant drops gnt on that same edge; no revoke pulse.
- ptr is a $clog2(WIDTH)-bit register. It is the index of the highest-priority requester for the next arbitration.
- Arbitration logic (combinational, evaluated only in IDLE):
  - rot = ring_shift_right(req, sel=ptr), so rot[k] = req[(ptr+k) mod WIDTH].
  - k = index of the lowest set bit of rot.
  - win = (ptr+k) mod WIDTH, truncated to $clog2(WIDTH) bits, so wrap is natural.
- States:
  - IDLE:
    - If req != 0, go to GRANT at the next edge with gnt = 1<<win, gnt_idx = win, hold_cnt = 1.
    - Otherwise stay in IDLE.
    - Latency: req asserted in cycle N gives gnt in cycle N+1.
  - GRANT, release:
    - If req[gnt_idx] == 0, go to IDLE at the next edge.
    - Set gnt = 0 and ptr = gnt_idx+1 (mod WIDTH).
  - GRANT, revoke:
    - Applies when MAX_HOLD != 0, hold_cnt == MAX_HOLD, req[gnt_idx] == 1, and (req & ~gnt) != 0.
    - Go to IDLE with gnt = 0, revoke = 1 for one cycle, ptr = gnt_idx+1.
    - Release has priority over revoke when both hold in the same cycle; no revoke pulse is produced in that case.
  - GRANT, otherwise:
    - Stay in GRANT and keep gnt.
    - hold_cnt increments, saturating at MAX_HOLD.
    - If only the owner is requesting, there is no revoke even past MAX_HOLD.
- Turnaround: gnt is always low for at least one cycle between two grants. Back-to-back grants are never adjacent.
- Requests arriving or dropping for non-owners during GRANT have no effect on the grant.
- Since ptr moves to owner+1 after every grant, any continuously asserted request is granted within WIDTH-1 other grants.
- gnt, gnt_vld and gnt_idx change only at clock edges and are mutually consistent every cycle.

Test Plan:
1. Reset then single request:
   - Stimulus: rst_n=0 for 2 cycles, then req=8'h04 from cycle 3.
   - Response: all outputs 0 during reset; gnt=8'h04, gnt_idx=2 in cycle 4; drop req at cycle 10 -> gnt=0 at cycle 11, ptr=3.
2. Rotation fairness:
   - Stimulus: req=8'hFF held. Each owner drops its bit one cycle after its grant, then re-asserts it in the next cycle.
   - Response: gnt_idx sequence 0,1,2,...,7,0, with one idle cycle between grants.
3. Wrap-around:
   - Stimulus: set ptr=7 via a grant to 6 and its release, then req=8'h81.
   - Response: gnt_idx=7 first; after release, gnt_idx=0.
4. Hold limit:
   - Stimulus: MAX_HOLD=4, req=8'h03 held.
   - Response: gnt=8'h01 for exactly 4 cycles; revoke=1 in the cycle gnt drops; next gnt=8'h02.
   - Check: with req=8'h01 alone, the grant is held indefinitely and revoke stays 0.
5. Simultaneous release and revoke:
   - Stimulus: MAX_HOLD=4; owner drops req in the cycle hold_cnt==4 while another bit is set.
   - Response: gnt drops, revoke stays 0, ptr=owner+1.
6. Reset mid-grant:
   - Stimulus: rst_n=0 while gnt=8'h10.
   - Response: gnt=0 and revoke=0 at that edge; after reset, req=8'h30 gives gnt_idx=4 (ptr restored to 0).
